// File: rtl/smartcar_pkg.sv
// Shared types and constants for the smart-car drive datapath.
//   state_e   : tracing FSM states; the encoding doubles as the LED code
//   decode_e  : what a stable sensor pattern asks the FSM to do
//   turn_e    : remembered direction of the most recent turn
//   WHEEL_*   : per-wheel direction codes for the wheel driver stage
//   PAT_*     : 4-bit line sensor patterns (bit3 = leftmost sensor)
package smartcar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SEARCH = 3'd4,
    ST_LOST   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    DEC_FWD,
    DEC_TURN_L,
    DEC_TURN_R,
    DEC_SEARCH,
    DEC_HOLD
  } decode_e;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_e;

  localparam logic [1:0] WHEEL_FWD   = 2'b10;
  localparam logic [1:0] WHEEL_REV   = 2'b01;
  localparam logic [1:0] WHEEL_BRAKE = 2'b00;

  localparam logic [3:0] PAT_MID    = 4'b0110;
  localparam logic [3:0] PAT_MID_L  = 4'b0100;
  localparam logic [3:0] PAT_MID_R  = 4'b0010;
  localparam logic [3:0] PAT_L1     = 4'b1000;
  localparam logic [3:0] PAT_L2     = 4'b1100;
  localparam logic [3:0] PAT_L3     = 4'b1110;
  localparam logic [3:0] PAT_R1     = 4'b0001;
  localparam logic [3:0] PAT_R2     = 4'b0011;
  localparam logic [3:0] PAT_R3     = 4'b0111;
  localparam logic [3:0] PAT_NONE   = 4'b0000;

  // Line seen toward the left means the car must steer left. Anything not
  // listed (including all-ones at a crossing) leaves the state unchanged.
  function automatic decode_e decode_path(input logic [3:0] path);
    decode_e dec;
    case (path)
      PAT_MID, PAT_MID_L, PAT_MID_R: dec = DEC_FWD;
      PAT_L1, PAT_L2, PAT_L3:        dec = DEC_TURN_L;
      PAT_R1, PAT_R2, PAT_R3:        dec = DEC_TURN_R;
      PAT_NONE:                      dec = DEC_SEARCH;
      default:                       dec = DEC_HOLD;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/path_debounce.sv
// Line-sensor conditioning: 2-flop synchroniser followed by a tick-gated
// debounce that only accepts a pattern after DEB_TICKS identical samples.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_tick          : 1-cycle sample strobe
//   i_path_raw[3:0] : raw sensor bits from the board
//   o_path_stable   : last accepted pattern (0000 after reset)
module path_debounce
  import smartcar_pkg::*;
#(
  parameter int DEB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic [3:0] i_path_raw,
  output logic [3:0] o_path_stable
);

  localparam int CNT_W = $clog2(DEB_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_TICKS);

  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_cand;
  logic [3:0]       r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // A fresh candidate starts at one match; a repeat saturates at DEB_TICKS.
  always_comb begin
    if (r_sync2 == r_cand) begin
      w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    end else begin
      w_cnt_next = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_sync1 <= i_path_raw;
      r_sync2 <= r_sync1;
      if (i_tick) begin
        r_cand <= r_sync2;
        r_cnt  <= w_cnt_next;
        if (w_cnt_next == CNT_MAX) begin
          r_stable <= r_sync2;
        end
      end
    end
  end

  assign o_path_stable = r_stable;

endmodule

// File: rtl/drive_sequencer.sv
// Line-tracing drive sequencer: turns debounced line-sensor patterns into
// per-wheel direction codes and a ramped speed level for the PWM stage.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   speed_req[1:0]    : requested speed level 0..3 (asynchronous input)
//   en_tracing        : 1 = run line tracing (asynchronous input)
//   path_raw[3:0]     : raw sensor bits, bit3 leftmost, 1 = line seen
//   speed_sel[1:0]    : speed level to the PWM generator
//   wheel_l_ctl[1:0]  : left wheel code (10 fwd, 01 rev, 00 brake)
//   wheel_r_ctl[1:0]  : right wheel code
//   led_state[2:0]    : FSM state code
//   lost              : 1 while the line has been declared lost
module drive_sequencer
  import smartcar_pkg::*;
#(
  parameter int TICK_DIV     = 50000,
  parameter int DEB_TICKS    = 4,
  parameter int RAMP_TICKS   = 100,
  parameter int SEARCH_TICKS = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed_req,
  input  logic       en_tracing,
  input  logic [3:0] path_raw,
  output logic [1:0] speed_sel,
  output logic [1:0] wheel_l_ctl,
  output logic [1:0] wheel_r_ctl,
  output logic [2:0] led_state,
  output logic       lost
);

  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int RAMP_W   = $clog2(RAMP_TICKS + 1);
  localparam int SEARCH_W = $clog2(SEARCH_TICKS + 1);
  localparam logic [TICK_W-1:0]   TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [RAMP_W-1:0]   RAMP_LAST   = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_TICKS - 1);

  logic [TICK_W-1:0]   r_tick_cnt;
  logic                w_tick;
  logic [1:0]          r_speed_s1, r_speed_s2;
  logic                r_en_s1, r_en_s2;
  logic [3:0]          w_path_stable;
  decode_e             w_dec;
  state_e              r_state, w_state_next;
  turn_e               r_last_turn;
  logic [SEARCH_W-1:0] r_search_cnt;
  logic [RAMP_W-1:0]   r_ramp_cnt;
  logic [1:0]          r_speed;
  logic [1:0]          w_wheel_l, w_wheel_r;
  logic [1:0]          r_wheel_l, r_wheel_r;
  logic [2:0]          r_led;
  logic                r_lost;

  // Free-running control tick, independent of FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_tick_cnt <= '0;
    else        r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
  end
  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed_s1 <= '0;
      r_speed_s2 <= '0;
      r_en_s1    <= 1'b0;
      r_en_s2    <= 1'b0;
    end else begin
      r_speed_s1 <= speed_req;
      r_speed_s2 <= r_speed_s1;
      r_en_s1    <= en_tracing;
      r_en_s2    <= r_en_s1;
    end
  end

  path_debounce #(.DEB_TICKS(DEB_TICKS)) u_path_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_tick       (w_tick),
    .i_path_raw   (path_raw),
    .o_path_stable(w_path_stable)
  );

  // The FSM sees path_stable as it stood before this tick's debounce update,
  // because both are registered on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_dec        = decode_path(w_path_stable);
    if (!r_en_s2) begin
      w_state_next = ST_IDLE;
    end else if (w_tick) begin
      case (r_state)
        ST_IDLE: w_state_next = ST_FWD;
        ST_FWD, ST_TURN_L, ST_TURN_R: begin
          case (w_dec)
            DEC_FWD:    w_state_next = ST_FWD;
            DEC_TURN_L: w_state_next = ST_TURN_L;
            DEC_TURN_R: w_state_next = ST_TURN_R;
            DEC_SEARCH: w_state_next = ST_SEARCH;
            default:    w_state_next = r_state;
          endcase
        end
        ST_SEARCH: begin
          case (w_dec)
            DEC_FWD:    w_state_next = ST_FWD;
            DEC_TURN_L: w_state_next = ST_TURN_L;
            DEC_TURN_R: w_state_next = ST_TURN_R;
            default: begin
              // Count already holds SEARCH_TICKS-1 completed ticks here.
              if (r_search_cnt == SEARCH_LAST) w_state_next = ST_LOST;
            end
          endcase
        end
        ST_LOST: w_state_next = ST_LOST;
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Search timer restarts from zero on every entry into SEARCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_search_cnt <= '0;
      r_last_turn  <= TURN_LEFT;
    end else begin
      if (r_state != ST_SEARCH) r_search_cnt <= '0;
      else if (w_tick)          r_search_cnt <= r_search_cnt + 1'b1;
      if (r_state == ST_TURN_L)      r_last_turn <= TURN_LEFT;
      else if (r_state == ST_TURN_R) r_last_turn <= TURN_RIGHT;
    end
  end

  always_comb begin
    w_wheel_l = WHEEL_BRAKE;
    w_wheel_r = WHEEL_BRAKE;
    case (r_state)
      ST_FWD:    begin w_wheel_l = WHEEL_FWD; w_wheel_r = WHEEL_FWD; end
      ST_TURN_L: begin w_wheel_l = WHEEL_REV; w_wheel_r = WHEEL_FWD; end
      ST_TURN_R: begin w_wheel_l = WHEEL_FWD; w_wheel_r = WHEEL_REV; end
      ST_SEARCH: begin
        // Spin in place toward the side the line was last seen on.
        if (r_last_turn == TURN_LEFT) begin
          w_wheel_l = WHEEL_REV; w_wheel_r = WHEEL_FWD;
        end else begin
          w_wheel_l = WHEEL_FWD; w_wheel_r = WHEEL_REV;
        end
      end
      default: begin w_wheel_l = WHEEL_BRAKE; w_wheel_r = WHEEL_BRAKE; end
    endcase
  end

  // Speed decreases are applied at once; increases step one level per
  // RAMP_TICKS ticks so the motors never see a sudden surge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed    <= '0;
      r_ramp_cnt <= '0;
    end else if (r_state == ST_IDLE || r_state == ST_LOST) begin
      r_speed    <= '0;
      r_ramp_cnt <= '0;
    end else if (r_speed > r_speed_s2) begin
      r_speed    <= r_speed_s2;
      r_ramp_cnt <= '0;
    end else if (r_speed == r_speed_s2) begin
      r_ramp_cnt <= '0;
    end else if (w_tick) begin
      if (r_ramp_cnt == RAMP_LAST) begin
        r_speed    <= r_speed + 1'b1;
        r_ramp_cnt <= '0;
      end else begin
        r_ramp_cnt <= r_ramp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wheel_l <= WHEEL_BRAKE;
      r_wheel_r <= WHEEL_BRAKE;
      r_led     <= '0;
      r_lost    <= 1'b0;
    end else begin
      r_wheel_l <= w_wheel_l;
      r_wheel_r <= w_wheel_r;
      r_led     <= r_state;
      r_lost    <= (r_state == ST_LOST);
    end
  end

  assign speed_sel   = r_speed;
  assign wheel_l_ctl = r_wheel_l;
  assign wheel_r_ctl = r_wheel_r;
  assign led_state   = r_led;
  assign lost        = r_lost;

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
Sequences the car's speed and wheel-direction datapath from line-sensor input. It synchronises and debounces the 4-bit path detector and runs a tracing FSM with lost-line search and timeout. It ramps the speed level fed to the PWM generator and drives per-wheel direction codes. It sits between the raw board inputs and the PWM/wheel driver stage of the top-level design.

Parameters:
TICK_DIV, 50000, clk cycles per control tick (1 kHz at 50 MHz)
DEB_TICKS, 4, consecutive identical tick samples required to accept a new sensor pattern
RAMP_TICKS, 100, ticks per one-level speed increase
SEARCH_TICKS, 2000, ticks in SEARCH before declaring the line lost

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
speed_req  in  2  requested speed level 0..3
en_tracing  in  1  1 = run line tracing
path_raw  in  4  sensor bits, bit3 = leftmost, bit0 = rightmost, 1 = line seen
speed_sel  out  2  speed level to PWM generator
wheel_l_ctl  out  2  left wheel: 10 fwd, 01 rev, 00 brake
wheel_r_ctl  out  2  right wheel, same encoding
led_state  out  3  FSM state code
lost  out  1  1 while in LOST

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters cleared; path_stable=0000; last_turn=LEFT.
- Synchronisation: speed_req, en_tracing and path_raw each pass a 2-flop synchroniser. All logic below uses the synchronised values.
- tick: counter runs 0..TICK_DIV-1 and emits a 1-cycle pulse at wrap. The counter free-runs in all states.
- Debounce (on tick):
  - Sample equal to the candidate: increment the match count, saturating.
  - Sample different: the sample becomes the new candidate; count = 1.
  - path_stable <= candidate when the count reaches DEB_TICKS.
- FSM transitions are evaluated on tick, using path_stable as registered before that tick's debounce update. The one exception: en_tracing=0 forces IDLE on the next clk from any state, without waiting for a tick.
- Pattern decode:
  - 0110, 0100, 0010 -> FWD.
  - 1000, 1100, 1110 -> TURN_L.
  - 0001, 0011, 0111 -> TURN_R.
  - 0000 -> SEARCH.
  - 1111 and all other patterns -> hold the current state.
- States, with led_state code and outputs (L, R):
  - IDLE (0): 00/00. Goes to FWD on tick when en_tracing=1.
  - FWD (1): 10/10. Transitions per decode.
  - TURN_L (2): 01/10. Sets last_turn=LEFT. Transitions per decode.
  - TURN_R (3): 10/01. Sets last_turn=RIGHT. Transitions per decode.
  - SEARCH (4): spins toward last_turn with TURN_L/TURN_R wheel codes.
    - search_cnt is cleared on entry and increments per tick.
    - A decoded FWD/TURN_L/TURN_R pattern exits to that state.
    - search_cnt reaching SEARCH_TICKS goes to LOST.
  - LOST (5): 00/00, lost=1. Exits only via en_tracing=0 -> IDLE.
- Speed:
  - In IDLE and LOST: speed_sel=0 immediately and ramp_cnt=0.
  - Otherwise target = speed_req.
  - speed_sel > target: speed_sel = target on the next clk (decrease is immediate).
  - speed_sel < target: ramp_cnt counts ticks; at RAMP_TICKS, speed_sel increments by 1 and ramp_cnt clears.
  - speed_sel == target: ramp_cnt held at 0.
  - speed_sel never wraps and never exceeds 3.
- All outputs are registered. Wheel codes and led_state change on the clk after the state change.
- Reset asserted mid-operation clears everything at once. After release, operation restarts from IDLE.

Decomposition:
- Package smartcar_pkg holds:
  - state enum with led codes 0..5;
  - wheel codes WHEEL_FWD=10, WHEEL_REV=01, WHEEL_BRAKE=00;
  - sensor pattern constants and a decode function returning FWD/TURN_L/TURN_R/SEARCH/HOLD.
- One sub-module, path_debounce: the synchroniser plus the tick-gated debounce, outputting path_stable. It is parameterised by DEB_TICKS.

Test Plan:
Bench parameters: TICK_DIV=4, DEB_TICKS=2, RAMP_TICKS=2, SEARCH_TICKS=5.
1. Reset, en_tracing=1, speed_req=3, path_raw=0110 held -> IDLE->FWD; wheels 10/10; speed_sel steps 0,1,2,3, one step per 2 ticks; led_state=1.
2. In FWD, path_raw=1100 for 1 tick then back to 0110 -> no state change (glitch rejected). 1100 held 3 ticks -> TURN_L, wheels 01/10, led_state=2.
3. After TURN_R, path_raw=0000 held -> SEARCH with wheels 10/01. After 5 further ticks -> LOST, lost=1, speed_sel=0, wheels 00/00.
4. In SEARCH, 0010 appears and is held before the timeout -> FWD; lost stays 0; search_cnt cleared on the next SEARCH entry.
5. speed_sel=3, then speed_req=1 -> speed_sel=1 on the following clk. Then en_tracing=0 -> IDLE within 3 clks (sync + 1), speed_sel=0, wheels 00/00.
6. rst_n pulsed low mid-TURN_L -> all outputs 0 asynchronously. After release, path_raw=1111 held from IDLE with en_tracing=1 -> FWD, then held (1111 = hold).
